// File: rtl/bsg_fsb_client_credit_bridge.sv
// FSB client front-end: an input FIFO between the ring and a client, and an
// outbound arbiter that sends client packets and credit-return packets.
// Credits go back to dest_id_p in batches, or early as a partial batch after
// a stretch of idle cycles.
module bsg_fsb_client_credit_bridge #(
  parameter int width_p        = 80,
  parameter int els_p          = 8,
  parameter int dest_id_p      = 0,
  parameter int credit_batch_p = 4,
  parameter int idle_timeout_p = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  // ring -> client
  input  logic                         fsb_node_v_i,
  input  logic [width_p-1:0]           fsb_node_data_i,
  output logic                         fsb_node_ready_o,
  output logic                         client_v_o,
  output logic [width_p-1:0]           client_data_o,
  input  logic                         client_yumi_i,
  // client -> ring
  input  logic                         client_v_i,
  input  logic [width_p-1:0]           client_data_i,
  output logic                         client_ready_o,
  output logic                         fsb_node_v_o,
  output logic [width_p-1:0]           fsb_node_data_o,
  input  logic                         fsb_node_yumi_i,
  // debug
  output logic [$clog2(els_p+1)-1:0]   credit_count_o
);

  localparam int PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int CNT_W = $clog2(els_p + 1);
  localparam int TMR_W = (idle_timeout_p > 0) ? $clog2(idle_timeout_p + 1) : 1;

  localparam logic             FLUSH_EN = (idle_timeout_p != 0);
  localparam logic [3:0]       DEST_ID  = 4'(dest_id_p);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(els_p);
  localparam logic [CNT_W-1:0] CNT_BAT  = CNT_W'(credit_batch_p);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(idle_timeout_p);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_CREDIT = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [width_p-1:0] r_mem [els_p];
  logic [PTR_W-1:0]   r_wptr, r_rptr;
  logic [CNT_W-1:0]   r_fcnt;
  logic               w_full, w_empty, w_enq, w_deq;

  assign w_full  = (r_fcnt == CNT_FULL);
  assign w_empty = (r_fcnt == '0);
  // No bypass: an empty FIFO has nothing to dequeue, and a full one refuses
  // new data even if the head leaves this cycle.
  assign w_enq   = en_i & fsb_node_v_i & ~w_full;
  assign w_deq   = en_i & client_yumi_i & ~w_empty;

  assign fsb_node_ready_o = ~reset_i & en_i & ~w_full;
  assign client_v_o       = ~reset_i & en_i & ~w_empty;
  assign client_data_o    = r_mem[r_rptr];

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= fsb_node_data_i;
  end

  // Pointers and occupancy; power-of-two depth makes pointer wrap free.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter and idle timer
  // ---------------------------------------------------------------------------
  state_e             r_state, w_state_n;
  logic [CNT_W-1:0]   r_cnt, r_amt, w_cnt_sub;
  logic [TMR_W-1:0]   r_tmr;
  logic [width_p-1:0] r_data;
  logic               r_last_credit;
  logic               w_credit_sent, w_flush, w_credit_due, w_yield;
  logic               w_take_client, w_take_credit;

  assign w_credit_sent = en_i & (r_state == S_CREDIT) & fsb_node_yumi_i;
  assign w_cnt_sub     = w_credit_sent ? r_amt : '0;
  assign credit_count_o = r_cnt;

  // Consumed-but-unreturned count; a consume in the send cycle is kept.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_cnt <= '0;
    else if (en_i) r_cnt <= r_cnt - w_cnt_sub + CNT_W'(w_deq);
  end

  // Idle timer: restarts on any activity, counts only while credit is owed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_tmr <= '0;
    else if (en_i) begin
      if (w_deq | w_credit_sent)                  r_tmr <= '0;
      else if ((r_cnt != '0) && (r_tmr != TMR_MAX)) r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  assign w_flush      = FLUSH_EN & (r_tmr == TMR_MAX) & (r_cnt != '0);
  assign w_credit_due = (r_cnt >= CNT_BAT) | w_flush;
  // Right after a credit send, a waiting client packet goes first unless the
  // remote has run completely dry.
  assign w_yield      = r_last_credit & client_v_i & (r_cnt < CNT_FULL);

  // ---------------------------------------------------------------------------
  // Outbound FSM
  // ---------------------------------------------------------------------------
  // State and capture registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= S_IDLE;
      r_data        <= '0;
      r_amt         <= '0;
      r_last_credit <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_take_client) r_data <= client_data_i;
      if (w_take_credit) r_amt  <= r_cnt;
      if (w_credit_sent)      r_last_credit <= 1'b1;
      else if (w_take_client) r_last_credit <= 1'b0;
    end
  end

  // Next state and acceptance decisions; everything frozen when disabled.
  always_comb begin
    w_state_n     = r_state;
    w_take_client = 1'b0;
    w_take_credit = 1'b0;
    if (en_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_credit_due && !w_yield) begin
            w_state_n     = S_CREDIT;
            w_take_credit = 1'b1;
          end else if (client_v_i) begin
            w_state_n     = S_DATA;
            w_take_client = 1'b1;
          end
        end
        S_DATA:   if (fsb_node_yumi_i) w_state_n = S_IDLE;
        S_CREDIT: if (fsb_node_yumi_i) w_state_n = S_IDLE;
        default:  w_state_n = S_IDLE;
      endcase
    end
  end

  // Credit packet: dest id on top, control flag below it, count in low byte.
  logic [width_p-1:0] w_credit_pkt;
  always_comb begin
    w_credit_pkt                    = '0;
    w_credit_pkt[width_p-1 -: 4]    = DEST_ID;
    w_credit_pkt[width_p-5]         = 1'b1;
    w_credit_pkt[7:0]               = 8'(r_amt);
  end

  assign client_ready_o  = ~reset_i & w_take_client;
  assign fsb_node_v_o    = ~reset_i & en_i & (r_state != S_IDLE);
  assign fsb_node_data_o = (r_state == S_CREDIT) ? w_credit_pkt : r_data;

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    client_yumi_i |-> client_v_o);
  a_cnt_bound:  assert property (@(posedge clk_i) disable iff (reset_i)
    r_cnt <= CNT_FULL);

endmodule

// File: tb/tb_bsg_fsb_client_credit_bridge.sv
// Directed bench: FIFO fill/wrap table plus hand sequences for credit batch,
// idle flush, arbitration priority, back-pressure, enable and reset.
module tb_bsg_fsb_client_credit_bridge;
  localparam int W = 80;

  logic         clk_i = 1'b0, reset_i, en_i;
  logic         fsb_node_v_i, client_yumi_i, client_v_i, fsb_node_yumi_i;
  logic [W-1:0] fsb_node_data_i, client_data_i;
  logic         fsb_node_ready_o, client_v_o, client_ready_o, fsb_node_v_o;
  logic [W-1:0] client_data_o, fsb_node_data_o;
  logic [3:0]   credit_count_o;
  // second instance with flush disabled
  logic         d0_ready, d0_cv, d0_cready, d0_fv;
  logic [W-1:0] d0_cdata, d0_fdata;
  logic [3:0]   d0_cnt;

  always #5 clk_i = ~clk_i;

  bsg_fsb_client_credit_bridge #(.width_p(W), .els_p(8), .dest_id_p(10),
    .credit_batch_p(4), .idle_timeout_p(16)) u_dut (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
    .fsb_node_v_i(fsb_node_v_i), .fsb_node_data_i(fsb_node_data_i),
    .fsb_node_ready_o(fsb_node_ready_o), .client_v_o(client_v_o),
    .client_data_o(client_data_o), .client_yumi_i(client_yumi_i),
    .client_v_i(client_v_i), .client_data_i(client_data_i),
    .client_ready_o(client_ready_o), .fsb_node_v_o(fsb_node_v_o),
    .fsb_node_data_o(fsb_node_data_o), .fsb_node_yumi_i(fsb_node_yumi_i),
    .credit_count_o(credit_count_o));

  bsg_fsb_client_credit_bridge #(.width_p(W), .els_p(8), .dest_id_p(10),
    .credit_batch_p(4), .idle_timeout_p(0)) u_dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
    .fsb_node_v_i(fsb_node_v_i), .fsb_node_data_i(fsb_node_data_i),
    .fsb_node_ready_o(d0_ready), .client_v_o(d0_cv),
    .client_data_o(d0_cdata), .client_yumi_i(client_yumi_i),
    .client_v_i(client_v_i), .client_data_i(client_data_i),
    .client_ready_o(d0_cready), .fsb_node_v_o(d0_fv),
    .fsb_node_data_o(d0_fdata), .fsb_node_yumi_i(fsb_node_yumi_i),
    .credit_count_o(d0_cnt));

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         yumi;
    logic         exp_rdy;
    logic         exp_cv;
    logic [W-1:0] exp_d;
  } vec_t;

  vec_t vecs[25];
  int   checks = 0, failures = 0;
  int   rdy_pulses = 0;

  always @(posedge clk_i) if (client_ready_o) rdy_pulses++;

  function automatic vec_t mk(logic v, int d, logic y, logic r, logic cv, int ed);
    vec_t t;
    t.v = v; t.d = W'(d); t.yumi = y; t.exp_rdy = r; t.exp_cv = cv; t.exp_d = W'(ed);
    return t;
  endfunction

  function automatic logic [W-1:0] cpkt(int n);
    logic [W-1:0] p;
    p = '0;
    p[W-1 -: 4] = 4'hA;
    p[W-5]      = 1'b1;
    p[7:0]      = n[7:0];
    return p;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; en_i = 1'b1;
    fsb_node_v_i = 0; client_yumi_i = 0; client_v_i = 0; fsb_node_yumi_i = 0;
    fsb_node_data_i = '0; client_data_i = '0;
    tick(); tick();
    reset_i = 1'b0;
    tick();
  endtask

  task automatic push(int base, int n);
    for (int i = 0; i < n; i++) begin
      fsb_node_v_i = 1'b1; fsb_node_data_i = W'(base + i); tick();
    end
    fsb_node_v_i = 1'b0;
  endtask

  task automatic consume(int n);
    for (int i = 0; i < n; i++) begin
      client_yumi_i = 1'b1; tick();
    end
    client_yumi_i = 1'b0;
  endtask

  initial begin #400000; $display("FAIL watchdog expired"); $fatal(1); end

  initial begin
    int n, p0;
    logic d0_seen;
    logic [W-1:0] dpay;

    // ---------------- reset state ----------------
    reset_i = 1'b1; en_i = 1'b1;
    fsb_node_v_i = 0; client_yumi_i = 0; fsb_node_yumi_i = 0;
    client_v_i = 1'b1; fsb_node_data_i = '0; client_data_i = W'(5);
    tick(); #1;
    chk("rst_ready",   W'(fsb_node_ready_o), W'(0));
    chk("rst_cv",      W'(client_v_o),       W'(0));
    chk("rst_fv",      W'(fsb_node_v_o),     W'(0));
    chk("rst_cready",  W'(client_ready_o),   W'(0));
    chk("rst_cnt",     W'(credit_count_o),   W'(0));
    do_reset();

    // ---------------- FIFO fill / wrap table ----------------
    n = 0;
    for (int k = 0; k < 9; k++) vecs[n++] = mk(1, k + 1, 0, k < 8, k > 0, 1);
    for (int r = 0; r < 8; r++) vecs[n++] = mk(1, 20 + r, 1, r != 0, 1, r + 1);
    for (int r = 0; r < 7; r++) vecs[n++] = mk(0, 0, 1, 1, 1, 21 + r);
    vecs[n++] = mk(0, 0, 0, 1, 0, 0);
    fsb_node_yumi_i = 1'b1;  // ring always drains credits here
    for (int i = 0; i < 25; i++) begin
      fsb_node_v_i = vecs[i].v; fsb_node_data_i = vecs[i].d; client_yumi_i = vecs[i].yumi;
      #1;
      chk($sformatf("tbl%0d_ready", i), W'(fsb_node_ready_o), W'(vecs[i].exp_rdy));
      chk($sformatf("tbl%0d_cv", i),    W'(client_v_o),       W'(vecs[i].exp_cv));
      if (vecs[i].exp_cv) chk($sformatf("tbl%0d_data", i), client_data_o, vecs[i].exp_d);
      tick();
    end
    fsb_node_v_i = 0; client_yumi_i = 0; fsb_node_yumi_i = 0;

    // ---------------- full batch credit ----------------
    do_reset();
    push(100, 4);
    consume(3);
    chk("bat_no_credit_3", W'(fsb_node_v_o), W'(0));
    consume(1);
    chk("bat_cnt4",   W'(credit_count_o), W'(4));
    chk("bat_v_pre",  W'(fsb_node_v_o),   W'(0));
    tick();
    chk("bat_v",      W'(fsb_node_v_o),   W'(1));
    chk("bat_pkt",    fsb_node_data_o,    cpkt(4));
    fsb_node_yumi_i = 1'b1; tick(); fsb_node_yumi_i = 1'b0;
    chk("bat_cnt0",   W'(credit_count_o), W'(0));
    chk("bat_v_post", W'(fsb_node_v_o),   W'(0));

    // ---------------- idle flush / flush disabled ----------------
    do_reset();
    push(200, 2);
    consume(2);
    n = 0; d0_seen = 1'b0;
    while (!fsb_node_v_o && n < 40) begin
      tick(); n++;
      if (d0_fv) d0_seen = 1'b1;
    end
    chk("flush_delay", W'(n),            W'(17));
    chk("flush_pkt",   fsb_node_data_o,  cpkt(2));
    chk("noflush_v",   W'(d0_seen),      W'(0));
    chk("noflush_cnt", W'(d0_cnt),       W'(2));
    fsb_node_yumi_i = 1'b1; tick(); fsb_node_yumi_i = 1'b0;
    chk("flush_cnt0",  W'(credit_count_o), W'(0));

    // ---------------- credit priority over client ----------------
    do_reset();
    push(300, 4);
    consume(4);
    p0 = rdy_pulses;
    dpay = {16'hC0DE, 64'h0123_4567_89AB_CDEF};
    client_v_i = 1'b1; client_data_i = dpay;
    #1;
    chk("pri_no_take",   W'(client_ready_o), W'(0));
    tick();
    chk("pri_credit_v",  W'(fsb_node_v_o),   W'(1));
    chk("pri_credit_pkt", fsb_node_data_o,   cpkt(4));
    fsb_node_yumi_i = 1'b1; tick(); fsb_node_yumi_i = 1'b0;
    chk("pri_take",      W'(client_ready_o), W'(1));
    chk("pri_idle",      W'(fsb_node_v_o),   W'(0));
    tick();
    client_v_i = 1'b0; client_data_i = '0;
    #1;
    chk("pri_data_v",    W'(fsb_node_v_o),   W'(1));
    chk("pri_data",      fsb_node_data_o,    dpay);
    fsb_node_yumi_i = 1'b1; tick(); fsb_node_yumi_i = 1'b0;
    chk("pri_done",      W'(fsb_node_v_o),   W'(0));
    chk("pri_pulses",    W'(rdy_pulses - p0), W'(1));

    // ---------------- back-pressure on credit packet ----------------
    do_reset();
    push(400, 6);
    consume(4);
    tick();
    for (int c = 0; c < 10; c++) begin
      client_yumi_i = (c < 2);
      #1;
      chk($sformatf("hold%0d_v", c), W'(fsb_node_v_o), W'(1));
      chk($sformatf("hold%0d_d", c), fsb_node_data_o,  cpkt(4));
      tick();
    end
    client_yumi_i = 1'b0;
    chk("hold_cnt6", W'(credit_count_o), W'(6));
    fsb_node_yumi_i = 1'b1; tick(); fsb_node_yumi_i = 1'b0;
    chk("hold_cnt2", W'(credit_count_o), W'(2));

    // ---------------- enable freeze, then async reset ----------------
    do_reset();
    push(500, 3);
    consume(1);
    dpay = W'(80'hBEEF_0000_0000_0000_1234);
    client_v_i = 1'b1; client_data_i = dpay;
    #1;
    chk("en_take", W'(client_ready_o), W'(1));
    tick();
    client_v_i = 1'b0;
    en_i = 1'b0; fsb_node_v_i = 1'b1; fsb_node_data_i = W'(999);
    client_v_i = 1'b1; fsb_node_yumi_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("en%0d_ready", c),  W'(fsb_node_ready_o), W'(0));
      chk($sformatf("en%0d_cv", c),     W'(client_v_o),       W'(0));
      chk($sformatf("en%0d_fv", c),     W'(fsb_node_v_o),     W'(0));
      chk($sformatf("en%0d_cready", c), W'(client_ready_o),   W'(0));
      chk($sformatf("en%0d_cnt", c),    W'(credit_count_o),   W'(1));
      tick();
    end
    en_i = 1'b1; fsb_node_v_i = 1'b0; client_v_i = 1'b0; fsb_node_yumi_i = 1'b0;
    #1;
    chk("en_resume_fv",   W'(fsb_node_v_o),   W'(1));
    chk("en_resume_data", fsb_node_data_o,    dpay);
    chk("en_resume_head", client_data_o,      W'(501));
    chk("en_resume_cnt",  W'(credit_count_o), W'(1));
    reset_i = 1'b1;
    #1;
    chk("arst_fv",    W'(fsb_node_v_o),     W'(0));
    chk("arst_cv",    W'(client_v_o),       W'(0));
    chk("arst_ready", W'(fsb_node_ready_o), W'(0));
    chk("arst_cnt",   W'(credit_count_o),   W'(0));
    tick(); tick();
    reset_i = 1'b0;
    tick();
    chk("post_rst_cv",    W'(client_v_o),       W'(0));
    chk("post_rst_ready", W'(fsb_node_ready_o), W'(1));
    chk("post_rst_fv",    W'(fsb_node_v_o),     W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
